uart_tx_fifo_drain: RTL and testbench
=====================================

// Module: uart_tx_fifo_drain
// PURPOSE
//  Consumer side of the BRAM-backed fifo: pops words from the fifo read port and serializes them as UART frames.
//  Handles the fifo's registered (1-cycle) BRAM read latency and read-during-write hazard internally.
//  Sits between a fifo instance (dataWidth_p = 8) and the board TX pin; CPU/peripherals push, this block drains.
// PARAMETERS
//  clkDiv_p    104  clocks per bit (>= 4); e.g. 12 MHz / 115200
//  dataWidth_p 8    data bits per frame, LSB first (5..9)
//  stopBits_p  1    stop bits, 1 or 2
// PORTS
//  clk_i        in   1            system clock, all logic on rising edge
//  rst_ni       in   1            asynchronous, active-low reset
//  fifo_empty_i in   1            fifo empty_o
//  fifo_data_i  in   dataWidth_p  fifo data_o (head word, valid 1 cycle after read index settles)
//  fifo_read_o  out  1            one-cycle pop strobe to fifo read_i
//  tx_o         out  1            UART line, idle high
//  busy_o       out  1            high from leaving IDLE until end of last stop bit
// BEHAVIOUR
//  Reset (async assert, sync release): tx_o=1, fifo_read_o=0, busy_o=0, state=IDLE, counters=0, shift reg=0.
//  States: IDLE -> SETTLE -> START -> DATA -> [PARITY] -> STOP -> IDLE (or SETTLE directly).
//  IDLE: tx_o=1. If !fifo_empty_i -> SETTLE, settle count=0.
//  SETTLE: 2 cycles with fifo_empty_i low (covers write->read same-address hazard + BRAM latency).
//   If fifo_empty_i goes high in SETTLE -> IDLE, no pop. On 2nd cycle: latch fifo_data_i into shift reg,
//   assert fifo_read_o for exactly that cycle, -> START. Never pop while fifo_empty_i=1.
//  START: tx_o=0 for clkDiv_p cycles. DATA: dataWidth_p bits, LSB first, clkDiv_p cycles each.
//  STOP: tx_o=1 for stopBits_p*clkDiv_p cycles. At end: if !fifo_empty_i -> SETTLE else IDLE.
//   Back-to-back gap = 2 SETTLE cycles (idle-high) between frames; the pop-to-next-latch distance is >= 1 frame,
//   so the new head is always settled.
//  Bit timer: counts 0..clkDiv_p-1, cleared on entry to START; bit boundary when count==clkDiv_p-1.
//   Bit counter width $clog2(dataWidth_p+1); no wrap: DATA exits when count reaches dataWidth_p-1 at boundary.
//  tx_o is registered (glitch-free); frame length = (1+dataWidth_p+P+stopBits_p)*clkDiv_p cycles, P=parity bit.
//  busy_o high in SETTLE..STOP; drops the cycle the block returns to IDLE.
//  Reset mid-frame: tx_o forced high immediately; the popped word is lost (not re-fetched).
//  fifo overflow (head ejection) while in SETTLE is a system error; the latched word is the head as of the prior cycle.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state inserted after DATA, one bit time, tx_o = even parity (XOR of data bits).
//  Not defined: no PARITY state, frame is 8N1-style (start, data, stop).
// STRUCTURE
//  Shared header uart_defs.vh (include-guarded): state encodings (IDLE, SETTLE, START, DATA, PARITY, STOP),
//   UART_SETTLE_CYCLES = 2, shared with the future UART receiver.
//  Sub-module uart_baud_tick: clkDiv_p counter with sync clear input and tick output; reused by the receiver.
//  FSM, shift register and fifo handshake stay in this module.
// TESTING
//  1. Reset with fifo holding 0xA5 -> tx_o=1, fifo_read_o=0 throughout reset; after release: 2 SETTLE cycles, one pop.
//  2. Single word 0x35, clkDiv_p=4 -> tx_o = 0,1,0,1,0,1,1,0,0,1 per bit (start, LSB..MSB, stop), 4 cycles each, 40 total.
//  3. Three words 0x01,0x80,0xFF queued -> three frames separated by exactly 2 idle-high cycles, exactly 3 pops.
//  4. Word written the same cycle fifo is observed non-empty -> transmitted value equals written value (hazard covered).
//  5. rst_ni pulled low mid-DATA of 0x55 -> tx_o=1 asynchronously, busy_o=0; after release, next fifo word sent intact.
//  6. UART_TX_PARITY_EN, 0x07 -> parity bit 1; 0x03 -> parity bit 0; frame length 11*clkDiv_p cycles.
//  Assertions: fifo_read_o never high with fifo_empty_i; fifo_read_o never high two consecutive cycles.

Source files
------------

// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared UART definitions: FSM state encoding and the settle length used
// between a fifo becoming non-empty and latching its head word. Kept in a
// package so the future UART receiver can import the same definitions.
package uart_tx_fifo_drain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    // Cycles spent in SETTLE before the head word is latched and popped.
    localparam int unsigned UART_SETTLE_CYCLES = 2;

endpackage

// File: rtl/uart_tx_fifo_drain_baud_tick.sv
// uart_baud_tick: bit-time counter for the UART. Counts 0..clkDiv_p-1 and
// flags the last cycle of each bit time; a synchronous clear holds it at 0.
// Ports:
//   clk_i   - system clock
//   rst_ni  - asynchronous active-low reset
//   clear_i - synchronous clear; counter held at 0 and tick suppressed
//   tick_o  - high on the last cycle of a bit time (count == clkDiv_p-1)
module uart_baud_tick #(
    parameter int unsigned clkDiv_p = 104
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CntW = (clkDiv_p > 1) ? $clog2(clkDiv_p) : 1;

    logic [CntW-1:0] count;

    assign tick_o = !clear_i && (count == CntW'(clkDiv_p - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (clear_i || tick_o) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: drains a BRAM-backed fifo and serializes each word as
// a UART frame (start, data LSB first, [parity], stop). Two SETTLE cycles
// with the fifo non-empty precede every pop so the registered BRAM output
// and any same-address write have resolved before the head is latched.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// after the data bits; undefined gives start/data/stop frames.
// Ports:
//   clk_i        - system clock, rising edge
//   rst_ni       - asynchronous active-low reset
//   fifo_empty_i - fifo empty flag
//   fifo_data_i  - fifo head word (registered BRAM output)
//   fifo_read_o  - one-cycle pop strobe to the fifo
//   tx_o         - UART line, idle high, registered
//   busy_o       - high from leaving IDLE until the end of the last stop bit
module uart_tx_fifo_drain
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int unsigned clkDiv_p    = 104,
    parameter int unsigned dataWidth_p = 8,
    parameter int unsigned stopBits_p  = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   fifo_empty_i,
    input  logic [dataWidth_p-1:0] fifo_data_i,
    output logic                   fifo_read_o,
    output logic                   tx_o,
    output logic                   busy_o
);

    localparam int unsigned BitCntW = $clog2(dataWidth_p + 1);

    uart_state_t            state;
    logic [BitCntW-1:0]     bit_count;
    logic                   stop_count;
    logic                   settle_count;
    logic [dataWidth_p-1:0] shift;
    logic                   tx_q;
    logic                   busy_q;
    logic                   baud_clear;
    logic                   tick;
    logic                   settle_last;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q;
`endif

    // Bit timer runs only while a frame is on the line, so it is at 0 on
    // the first START cycle.
    assign baud_clear = (state == ST_IDLE) || (state == ST_SETTLE);

    uart_baud_tick #(
        .clkDiv_p(clkDiv_p)
    ) u_baud (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear_i(baud_clear),
        .tick_o (tick)
    );

    assign settle_last = (settle_count == 1'(UART_SETTLE_CYCLES - 1));

    // Pop strobe is decoded from registered state and gated by the live
    // empty flag, so it can never fire against an empty fifo.
    assign fifo_read_o = (state == ST_SETTLE) && settle_last && !fifo_empty_i;

    assign tx_o   = tx_q;
    assign busy_o = busy_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= ST_IDLE;
            bit_count    <= '0;
            stop_count   <= 1'b0;
            settle_count <= 1'b0;
            shift        <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty_i) begin
                        state        <= ST_SETTLE;
                        settle_count <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (fifo_empty_i) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else if (settle_last) begin
                        shift      <= fifo_data_i;
`ifdef UART_TX_PARITY_EN
                        parity_q   <= ^fifo_data_i;
`endif
                        state      <= ST_START;
                        tx_q       <= 1'b0;
                        bit_count  <= '0;
                        stop_count <= 1'b0;
                    end else begin
                        settle_count <= settle_count + 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state <= ST_DATA;
                        tx_q  <= shift[0];
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_count == BitCntW'(dataWidth_p - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
                            tx_q  <= parity_q;
`else
                            state <= ST_STOP;
                            tx_q  <= 1'b1;
`endif
                        end else begin
                            bit_count <= bit_count + 1'b1;
                            shift     <= shift >> 1;
                            tx_q      <= shift[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state <= ST_STOP;
                        tx_q  <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (stop_count == 1'(stopBits_p - 1)) begin
                            stop_count <= 1'b0;
                            if (!fifo_empty_i) begin
                                state        <= ST_SETTLE;
                                settle_count <= 1'b0;
                            end else begin
                                state  <= ST_IDLE;
                                busy_q <= 1'b0;
                            end
                        end else begin
                            stop_count <= stop_count + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain with clkDiv_p=4, 8 data bits and one
// stop bit. A small fifo model with a delayed write and registered read
// output stands in for the BRAM fifo. Build option: UART_TX_PARITY_EN.
module tb_uart_tx_fifo_drain;

    localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PBIT = 1;
`else
    localparam int PBIT = 0;
`endif
    localparam int NB    = 10 + PBIT;
    localparam int FRAME = NB * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_read;
    logic       tx;
    logic       busy;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_drain #(
        .clkDiv_p   (DIV),
        .dataWidth_p(8),
        .stopBits_p (1)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .fifo_empty_i(fifo_empty),
        .fifo_data_i (fifo_data),
        .fifo_read_o (fifo_read),
        .tx_o        (tx),
        .busy_o      (busy)
    );

    // Fifo model: write lands one cycle after the push, read data is
    // registered, so the head lags the empty flag by two cycles.
    logic [7:0] mem [16] = '{default: 8'hEE};
    logic [3:0] wp = '0;
    logic [3:0] rp = '0;
    logic       wr_pend = 1'b0;
    logic [3:0] wr_addr_q = '0;
    logic [7:0] wr_data_q = '0;
    logic [7:0] dq = 8'hEE;
    int         occ = 0;
    int         pops = 0;
    logic       push_en = 1'b0;
    logic [7:0] push_d = '0;

    always @(posedge clk) begin
        wr_pend   <= push_en;
        wr_addr_q <= wp;
        wr_data_q <= push_d;
        if (push_en) wp <= wp + 4'd1;
        if (wr_pend) mem[wr_addr_q] <= wr_data_q;
        dq <= mem[rp];
        if (fifo_read) begin
            rp   <= rp + 4'd1;
            pops <= pops + 1;
        end
        occ <= occ + (push_en ? 1 : 0) - (fifo_read ? 1 : 0);
    end

    assign fifo_empty = (occ == 0);
    assign fifo_data  = dq;

    // Protocol monitor: no pop while empty, no pop on consecutive cycles.
    int   viol = 0;
    logic prev_read = 1'b0;
    always @(posedge clk) begin
        viol <= viol + ((fifo_read && fifo_empty) ? 1 : 0)
                     + ((fifo_read && prev_read) ? 1 : 0);
        prev_read <= fifo_read;
    end

    logic trace [512];
    logic btr   [512];

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        push_en = 1'b1;
        push_d  = d;
        @(negedge clk);
        push_en = 1'b0;
    endtask

    // Waits for the start bit, then records tx/busy for n cycles; index 0 is
    // the first start-bit cycle.
    task automatic capture(input int n, output bit ok);
        int w = 0;
        ok = 1'b0;
        while (w < 400 && !ok) begin
            @(negedge clk);
            if (tx === 1'b0) ok = 1'b1;
            else w++;
        end
        if (ok) begin
            trace[0] = tx;
            btr[0]   = busy;
            for (int i = 1; i < n; i++) begin
                @(negedge clk);
                trace[i] = tx;
                btr[i]   = busy;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        int w = 0;
        ok = 1'b0;
        while (w < 600 && !ok) begin
            @(negedge clk);
            if (busy === 1'b0) ok = 1'b1;
            else w++;
        end
    endtask

    function automatic logic [7:0] dec(input int base);
        logic [7:0] d;
        for (int i = 0; i < 8; i++) d[i] = trace[base + (1 + i) * DIV + DIV / 2];
        return d;
    endfunction

    task automatic test_reset();
        bit ok;
        push(8'hA5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx);
            else passed++;
            total++;
            if (fifo_read !== 1'b0) $display("FAIL reset_read: got %b expected 0", fifo_read);
            else passed++;
            total++;
            if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
            else passed++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (fifo_read !== 1'b0 || busy !== 1'b1)
            $display("FAIL settle1: got read=%b busy=%b expected read=0 busy=1", fifo_read, busy);
        else passed++;
        @(negedge clk);
        total++;
        if (fifo_read !== 1'b1 || tx !== 1'b1)
            $display("FAIL settle2_pop: got read=%b tx=%b expected read=1 tx=1", fifo_read, tx);
        else passed++;
        @(negedge clk);
        total++;
        if (fifo_read !== 1'b0 || tx !== 1'b0)
            $display("FAIL start_after_pop: got read=%b tx=%b expected read=0 tx=0", fifo_read, tx);
        else passed++;
        wait_idle(ok);
        total++;
        if (!ok || pops !== 1) $display("FAIL reset_pops: got idle=%0d pops=%0d expected idle=1 pops=1", ok, pops);
        else passed++;
    endtask

    task automatic test_single();
        bit ok;
        logic [7:0] d;
        logic e;
        d = 8'h35;
        push(d);
        capture(FRAME + 4, ok);
        total++;
        if (!ok) $display("FAIL single_start: got no start bit expected start bit");
        else passed++;
        for (int k = 0; k < NB; k++) begin
            if (k == 0) e = 1'b0;
            else if (k <= 8) e = d[k-1];
            else if (k == NB - 1) e = 1'b1;
            else e = ^d;
            total++;
            if (trace[k*DIV + 2] !== e) $display("FAIL single_bit%0d: got %b expected %b", k, trace[k*DIV + 2], e);
            else passed++;
        end
        total++;
        if (trace[DIV-1] !== 1'b0 || trace[DIV] !== 1'b1)
            $display("FAIL start_edge: got %b%b expected 01", trace[DIV-1], trace[DIV]);
        else passed++;
        total++;
        if (btr[FRAME-1] !== 1'b1 || btr[FRAME] !== 1'b0 || trace[FRAME-1] !== 1'b1)
            $display("FAIL frame_len: got busy=%b%b stop=%b expected busy=10 stop=1",
                     btr[FRAME-1], btr[FRAME], trace[FRAME-1]);
        else passed++;
        wait_idle(ok);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int p0;
        logic [7:0] words [3];
        words[0] = 8'h01;
        words[1] = 8'h80;
        words[2] = 8'hFF;
        p0 = pops;
        @(negedge clk);
        push_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_d = words[i];
            @(negedge clk);
        end
        push_en = 1'b0;
        capture(3 * FRAME + 12, ok);
        total++;
        if (!ok) $display("FAIL b2b_start: got no start bit expected start bit");
        else passed++;
        for (int f = 0; f < 3; f++) begin
            total++;
            if (dec(f * (FRAME + 2)) !== words[f])
                $display("FAIL b2b_data%0d: got %h expected %h", f, dec(f * (FRAME + 2)), words[f]);
            else passed++;
        end
        for (int g = 1; g < 3; g++) begin
            total++;
            if (trace[g*(FRAME+2)-2] !== 1'b1 || trace[g*(FRAME+2)-1] !== 1'b1 || trace[g*(FRAME+2)] !== 1'b0)
                $display("FAIL b2b_gap%0d: got %b%b%b expected 110", g,
                         trace[g*(FRAME+2)-2], trace[g*(FRAME+2)-1], trace[g*(FRAME+2)]);
            else passed++;
        end
        total++;
        if (btr[FRAME] !== 1'b1) $display("FAIL b2b_busy_gap: got %b expected 1", btr[FRAME]);
        else passed++;
        wait_idle(ok);
        total++;
        if (!ok || pops - p0 !== 3) $display("FAIL b2b_pops: got %0d expected 3", pops - p0);
        else passed++;
    endtask

    task automatic test_hazard();
        bit ok;
        push(8'h3C);
        capture(FRAME + 2, ok);
        total++;
        if (!ok || dec(0) !== 8'h3C) $display("FAIL hazard_data: got %h expected 3c", dec(0));
        else passed++;
        wait_idle(ok);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int p0;
        p0 = pops;
        push(8'h55);
        capture(3 * DIV, ok);
        total++;
        if (!ok || trace[2*DIV + 2] !== 1'b0) $display("FAIL mid_bit1: got %b expected 0", trace[2*DIV + 2]);
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (tx !== 1'b1 || busy !== 1'b0)
            $display("FAIL mid_reset: got tx=%b busy=%b expected tx=1 busy=0", tx, busy);
        else passed++;
        push(8'h96);
        @(negedge clk);
        rst_n = 1'b1;
        capture(FRAME + 2, ok);
        total++;
        if (!ok || dec(0) !== 8'h96) $display("FAIL mid_next_word: got %h expected 96", dec(0));
        else passed++;
        wait_idle(ok);
        total++;
        if (!ok || pops - p0 !== 2) $display("FAIL mid_pops: got %0d expected 2", pops - p0);
        else passed++;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        bit ok;
        logic [7:0] words [2];
        logic       pexp  [2];
        words[0] = 8'h07;
        pexp[0]  = 1'b1;
        words[1] = 8'h03;
        pexp[1]  = 1'b0;
        for (int w = 0; w < 2; w++) begin
            push(words[w]);
            capture(FRAME + 2, ok);
            total++;
            if (!ok || dec(0) !== words[w]) $display("FAIL par_data%0d: got %h expected %h", w, dec(0), words[w]);
            else passed++;
            total++;
            if (trace[9*DIV + 2] !== pexp[w])
                $display("FAIL par_bit%0d: got %b expected %b", w, trace[9*DIV + 2], pexp[w]);
            else passed++;
            total++;
            if (trace[FRAME-2] !== 1'b1 || btr[FRAME-1] !== 1'b1 || btr[FRAME] !== 1'b0)
                $display("FAIL par_len%0d: got stop=%b busy=%b%b expected stop=1 busy=10",
                         w, trace[FRAME-2], btr[FRAME-1], btr[FRAME]);
            else passed++;
            wait_idle(ok);
        end
    endtask
`endif

    task automatic test_protocol();
        total++;
        if (viol !== 0) $display("FAIL pop_protocol: got %0d violations expected 0", viol);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hazard();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_protocol();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
